// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the N-channel memory arbiter.
package mem_arb_pkg;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_e;

    localparam int STAT_W = 16;

    // Index width that never collapses to zero bits, even for a single channel.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Rotated-priority picker: first asserted request searching ptr, ptr+1, ... modulo NUM_CH.
module mem_arb_rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = clog2_min1(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic              any,
    output logic [IDX_W-1:0]  idx
);

    generate
        if (NUM_CH == 1) begin : g_single
            assign any = req[0];
            assign idx = '0;
        end else begin : g_multi
            logic [2*NUM_CH-1:0] req2;
            logic [NUM_CH-1:0]   rot;
            logic [IDX_W:0]      ptr_x;
            logic [IDX_W:0]      off;
            logic [IDX_W:0]      sum;

            // Doubling the request vector turns the wrap-around search into a plain slice.
            assign req2  = {req, req};
            assign ptr_x = {1'b0, ptr};
            assign rot   = req2[ptr_x +: NUM_CH];
            assign any   = |req;

            always_comb begin
                off = '0;
                for (int i = NUM_CH - 1; i >= 0; i--) begin
                    if (rot[i]) off = (IDX_W + 1)'(i);
                end
                sum = ptr_x + off;
                if (sum >= (IDX_W + 1)'(NUM_CH)) sum = sum - (IDX_W + 1)'(NUM_CH);
                idx = IDX_W'(sum);
            end
        end
    endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin NUM_CH-to-1 arbiter onto a single-port memory with registered grant.
// Define MEM_ARB_STATS_EN to add per-channel saturating completion counters (stat_cnt_o).
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = `RISCV_ADDR_WIDTH,
    parameter int DATA_W = `RISCV_WORD_WIDTH,
    localparam int BE_W  = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        s_valid_i,
    output logic [NUM_CH-1:0]        s_ready_o,
    input  logic [NUM_CH*ADDR_W-1:0] s_addr_i,
    input  logic [NUM_CH*DATA_W-1:0] s_wdata_i,
    input  logic [NUM_CH*BE_W-1:0]   s_we_i,
    output logic [DATA_W-1:0]        s_rdata_o,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic [ADDR_W-1:0]        m_addr_o,
    output logic [DATA_W-1:0]        m_wdata_o,
    output logic [BE_W-1:0]          m_we_o,
    input  logic [DATA_W-1:0]        m_rdata_i
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [NUM_CH*STAT_W-1:0] stat_cnt_o
`endif
);

    localparam int IDX_W = clog2_min1(NUM_CH);

    arb_state_e       state;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] next_ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             busy;

    mem_arb_rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req (s_valid_i),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign busy     = (state == BUSY);
    assign next_ptr = (grant == IDX_W'(NUM_CH - 1)) ? '0 : grant + IDX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant <= pick_idx;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // Served channel drops to the back of the rotation.
                    if (m_ready_i) begin
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        m_addr_o  = '0;
        m_wdata_o = '0;
        m_we_o    = '0;
        s_ready_o = '0;
        if (busy) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (grant == IDX_W'(k)) begin
                    m_addr_o     = s_addr_i[k*ADDR_W +: ADDR_W];
                    m_wdata_o    = s_wdata_i[k*DATA_W +: DATA_W];
                    m_we_o       = s_we_i[k*BE_W +: BE_W];
                    s_ready_o[k] = m_ready_i;
                end
            end
        end
    end

    assign m_valid_o = busy;
    assign s_rdata_o = m_rdata_i;

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cnt_o <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (s_ready_o[k] && (stat_cnt_o[k*STAT_W +: STAT_W] != '1))
                    stat_cnt_o[k*STAT_W +: STAT_W] <= stat_cnt_o[k*STAT_W +: STAT_W] + STAT_W'(1);
            end
        end
    end
`endif

`ifndef SYNTHESIS
    // A granted master must keep valid up until its ready.
    a_hold_valid: assert property (@(posedge clk) disable iff (!rst_n) busy |-> s_valid_i[grant])
        else $error("mem_arbiter: granted channel dropped valid before ready");
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter (2-channel and 4-channel instances).
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // 2-channel instance with a small byte-writable memory model
    logic [1:0]      valid_a, sready_a;
    logic [2*AW-1:0] addr_a;
    logic [2*DW-1:0] wdata_a;
    logic [2*BW-1:0] we_a;
    logic [DW-1:0]   srdata_a, mwdata_a, mrdata_a;
    logic            mvalid_a, mready_a;
    logic [AW-1:0]   maddr_a;
    logic [BW-1:0]   mwe_a;
    logic [31:0]     mem_a [16] = '{32'h0, 32'h11111111, 32'h22222222, 32'h33333333,
                                    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                    32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

    // 4-channel instance with an always-ready memory
    logic [3:0]      valid_b, sready_b;
    logic [4*AW-1:0] addr_b;
    logic [4*DW-1:0] wdata_b;
    logic [4*BW-1:0] we_b;
    logic [DW-1:0]   srdata_b, mwdata_b, mrdata_b;
    logic            mvalid_b, mready_b;
    logic [AW-1:0]   maddr_b;
    logic [BW-1:0]   mwe_b;

`ifdef MEM_ARB_STATS_EN
    logic [2*16-1:0] stat_a;
    logic [4*16-1:0] stat_b;
`endif

    mem_arbiter #(.NUM_CH(2), .ADDR_W(AW), .DATA_W(DW)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .s_valid_i(valid_a), .s_ready_o(sready_a), .s_addr_i(addr_a),
        .s_wdata_i(wdata_a), .s_we_i(we_a), .s_rdata_o(srdata_a),
        .m_valid_o(mvalid_a), .m_ready_i(mready_a), .m_addr_o(maddr_a),
        .m_wdata_o(mwdata_a), .m_we_o(mwe_a), .m_rdata_i(mrdata_a)
`ifdef MEM_ARB_STATS_EN
        , .stat_cnt_o(stat_a)
`endif
    );

    mem_arbiter #(.NUM_CH(4), .ADDR_W(AW), .DATA_W(DW)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .s_valid_i(valid_b), .s_ready_o(sready_b), .s_addr_i(addr_b),
        .s_wdata_i(wdata_b), .s_we_i(we_b), .s_rdata_o(srdata_b),
        .m_valid_o(mvalid_b), .m_ready_i(mready_b), .m_addr_o(maddr_b),
        .m_wdata_o(mwdata_b), .m_we_o(mwe_b), .m_rdata_i(mrdata_b)
`ifdef MEM_ARB_STATS_EN
        , .stat_cnt_o(stat_b)
`endif
    );

    assign mrdata_a = mem_a[maddr_a[11:8]];
    assign addr_b   = {32'h1030, 32'h1020, 32'h1010, 32'h1000};
    assign wdata_b  = '0;
    assign we_b     = '0;
    assign mready_b = 1'b1;
    assign mrdata_b = '0;

    always @(posedge clk) begin
        if (mvalid_a && mready_a) begin
            for (int b = 0; b < BW; b++)
                if (mwe_a[b]) mem_a[maddr_a[11:8]][b*8 +: 8] <= mwdata_a[b*8 +: 8];
        end
    end

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] addr0, addr1, wdata1;
        logic [3:0]  we1;
        logic        mrdy;
        logic        e_mval;
        logic [31:0] e_maddr, e_mwdata;
        logic [3:0]  e_mwe;
        logic [1:0]  e_sready;
        logic [31:0] e_rdata;
    } vec_a_t;

    typedef struct {
        logic [3:0]  valid;
        logic        e_mval;
        logic [31:0] e_maddr;
        logic [3:0]  e_sready;
    } vec_b_t;

    vec_a_t tab_a [20];
    vec_b_t tab_b [9];

    function automatic vec_a_t va(input logic [1:0] v, input logic [31:0] a0, a1, wd,
                                  input logic [3:0] we, input logic rdy, input logic ev,
                                  input logic [31:0] ea, ewd, input logic [3:0] ewe,
                                  input logic [1:0] esr, input logic [31:0] erd);
        vec_a_t r;
        r.valid = v; r.addr0 = a0; r.addr1 = a1; r.wdata1 = wd; r.we1 = we; r.mrdy = rdy;
        r.e_mval = ev; r.e_maddr = ea; r.e_mwdata = ewd; r.e_mwe = ewe;
        r.e_sready = esr; r.e_rdata = erd;
        return r;
    endfunction

    function automatic vec_b_t vb(input logic [3:0] v, input logic ev,
                                  input logic [31:0] ea, input logic [3:0] esr);
        vec_b_t r;
        r.valid = v; r.e_mval = ev; r.e_maddr = ea; r.e_sready = esr;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        valid_a = '0; addr_a = '0; wdata_a = '0; we_a = '0; mready_a = 1'b0;
        valid_b = '0;

        // ch0 read at 0x100, then both channels streaming (rr_ptr is 1 after the first read)
        tab_a[0]  = va(2'b01, 32'h100, 32'h0,   32'h0, 4'h0, 1'b1, 1'b0, 32'h0,   32'h0, 4'h0, 2'b00, 32'h0);
        tab_a[1]  = va(2'b01, 32'h100, 32'h0,   32'h0, 4'h0, 1'b1, 1'b1, 32'h100, 32'h0, 4'h0, 2'b01, 32'h11111111);
        tab_a[2]  = va(2'b00, 32'h0,   32'h0,   32'h0, 4'h0, 1'b1, 1'b0, 32'h0,   32'h0, 4'h0, 2'b00, 32'h0);
        tab_a[3]  = va(2'b11, 32'h200, 32'h300, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,   32'h0, 4'h0, 2'b00, 32'h0);
        tab_a[4]  = va(2'b11, 32'h200, 32'h300, 32'h0, 4'h0, 1'b1, 1'b1, 32'h300, 32'h0, 4'h0, 2'b10, 32'h33333333);
        tab_a[5]  = va(2'b11, 32'h200, 32'h300, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,   32'h0, 4'h0, 2'b00, 32'h0);
        tab_a[6]  = va(2'b11, 32'h200, 32'h300, 32'h0, 4'h0, 1'b1, 1'b1, 32'h200, 32'h0, 4'h0, 2'b01, 32'h22222222);
        tab_a[7]  = va(2'b11, 32'h200, 32'h300, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,   32'h0, 4'h0, 2'b00, 32'h0);
        tab_a[8]  = va(2'b11, 32'h200, 32'h300, 32'h0, 4'h0, 1'b1, 1'b1, 32'h300, 32'h0, 4'h0, 2'b10, 32'h33333333);
        tab_a[9]  = va(2'b11, 32'h200, 32'h300, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,   32'h0, 4'h0, 2'b00, 32'h0);
        tab_a[10] = va(2'b11, 32'h200, 32'h300, 32'h0, 4'h0, 1'b1, 1'b1, 32'h200, 32'h0, 4'h0, 2'b01, 32'h22222222);
        tab_a[11] = va(2'b00, 32'h0,   32'h0,   32'h0, 4'h0, 1'b1, 1'b0, 32'h0,   32'h0, 4'h0, 2'b00, 32'h0);
        // ch1 write with a 3-cycle stall, then ch0 reads it back
        tab_a[12] = va(2'b10, 32'h0, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 2'b00, 32'h0);
        tab_a[13] = va(2'b10, 32'h0, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0);
        tab_a[14] = va(2'b10, 32'h0, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0);
        tab_a[15] = va(2'b10, 32'h0, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0);
        tab_a[16] = va(2'b10, 32'h0, 32'h100, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 2'b10, 32'h11111111);
        tab_a[17] = va(2'b01, 32'h100, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,   32'h0, 4'h0, 2'b00, 32'h0);
        tab_a[18] = va(2'b01, 32'h100, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h100, 32'h0, 4'h0, 2'b01, 32'hDEADBEEF);
        tab_a[19] = va(2'b00, 32'h0,   32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,   32'h0, 4'h0, 2'b00, 32'h0);

        // 4 channels: ch1 served moves rr_ptr to 2, so ch3 wins over ch1, and later over ch0
        tab_b[0] = vb(4'b0010, 1'b0, 32'h0,    4'b0000);
        tab_b[1] = vb(4'b0010, 1'b1, 32'h1010, 4'b0010);
        tab_b[2] = vb(4'b1010, 1'b0, 32'h0,    4'b0000);
        tab_b[3] = vb(4'b1010, 1'b1, 32'h1030, 4'b1000);
        tab_b[4] = vb(4'b0010, 1'b0, 32'h0,    4'b0000);
        tab_b[5] = vb(4'b0010, 1'b1, 32'h1010, 4'b0010);
        tab_b[6] = vb(4'b1001, 1'b0, 32'h0,    4'b0000);
        tab_b[7] = vb(4'b1001, 1'b1, 32'h1030, 4'b1000);
        tab_b[8] = vb(4'b0000, 1'b0, 32'h0,    4'b0000);

        // Reset state: requests present but nothing reaches memory
        repeat (2) @(negedge clk);
        valid_a = 2'b11; addr_a = {32'h300, 32'h200}; mready_a = 1'b1; valid_b = 4'b1111;
        #1;
        chk("reset m_valid_a", 32'(mvalid_a), 32'h0);
        chk("reset m_addr_a", maddr_a, 32'h0);
        chk("reset s_ready_a", 32'(sready_a), 32'h0);
        chk("reset m_valid_b", 32'(mvalid_b), 32'h0);
        chk("reset s_ready_b", 32'(sready_b), 32'h0);
        valid_a = '0; addr_a = '0; mready_a = 1'b0; valid_b = '0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            valid_a  = tab_a[i].valid;
            addr_a   = {tab_a[i].addr1, tab_a[i].addr0};
            wdata_a  = {tab_a[i].wdata1, 32'h0};
            we_a     = {tab_a[i].we1, 4'h0};
            mready_a = tab_a[i].mrdy;
            #1;
            chk($sformatf("A[%0d] m_valid", i), 32'(mvalid_a), 32'(tab_a[i].e_mval));
            chk($sformatf("A[%0d] m_addr", i), maddr_a, tab_a[i].e_maddr);
            chk($sformatf("A[%0d] m_wdata", i), mwdata_a, tab_a[i].e_mwdata);
            chk($sformatf("A[%0d] m_we", i), 32'(mwe_a), 32'(tab_a[i].e_mwe));
            chk($sformatf("A[%0d] s_ready", i), 32'(sready_a), 32'(tab_a[i].e_sready));
            if (tab_a[i].e_sready != 2'b00)
                chk($sformatf("A[%0d] s_rdata", i), srdata_a, tab_a[i].e_rdata);
        end

        // Reset during a stalled ch1 transfer; afterwards ch0 wins from rr_ptr=0
        @(negedge clk);
        valid_a = 2'b10; addr_a = {32'h400, 32'h0}; wdata_a = '0; we_a = '0; mready_a = 1'b0;
        #1;
        chk("rstbusy idle m_valid", 32'(mvalid_a), 32'h0);
        @(negedge clk);
        #1;
        chk("rstbusy m_valid", 32'(mvalid_a), 32'h1);
        chk("rstbusy m_addr", maddr_a, 32'h400);
        rst_n = 1'b0;
        #1;
        chk("rstbusy async m_valid", 32'(mvalid_a), 32'h0);
        chk("rstbusy async m_addr", maddr_a, 32'h0);
        chk("rstbusy async s_ready", 32'(sready_a), 32'h0);
        @(negedge clk);
        valid_a = 2'b11; addr_a = {32'h400, 32'h500}; mready_a = 1'b1;
        rst_n = 1'b1;
        #1;
        chk("rearb idle m_valid", 32'(mvalid_a), 32'h0);
        @(negedge clk);
        #1;
        chk("rearb m_valid", 32'(mvalid_a), 32'h1);
        chk("rearb m_addr", maddr_a, 32'h500);
        chk("rearb s_ready", 32'(sready_a), 32'h1);
        @(negedge clk);
        valid_a = '0; addr_a = '0; mready_a = 1'b0;
        #1;
`ifdef MEM_ARB_STATS_EN
        chk("stat_a ch0", 32'(stat_a[15:0]), 32'h1);
        chk("stat_a ch1", 32'(stat_a[31:16]), 32'h0);
`endif

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            valid_b = tab_b[i].valid;
            #1;
            chk($sformatf("B[%0d] m_valid", i), 32'(mvalid_b), 32'(tab_b[i].e_mval));
            chk($sformatf("B[%0d] m_addr", i), maddr_b, tab_b[i].e_maddr);
            chk($sformatf("B[%0d] s_ready", i), 32'(sready_b), 32'(tab_b[i].e_sready));
        end
`ifdef MEM_ARB_STATS_EN
        chk("stat_b ch1", 32'(stat_b[31:16]), 32'h2);
        chk("stat_b ch3", 32'(stat_b[63:48]), 32'h2);
        chk("stat_b ch0", 32'(stat_b[15:0]), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised N-channel to 1-port memory arbiter for the core/memory subsystem.
- Lets NUM_CH valid/ready masters (imem fetch, dmem load/store, debug/DMA) share one single-port memory bank.
- Uses the same valid/ready/addr/wdata/we/rdata handshake the core uses on both memory interfaces.
- Round-robin fairness, registered grant, tolerant of multi-cycle memory ready.

Parameters:
- NUM_CH, 2, number of requesting channels (>=1)
- ADDR_W, `RISCV_ADDR_WIDTH, address width
- DATA_W, `RISCV_WORD_WIDTH, data width (multiple of 8); BE_W = DATA_W/8 is a derived localparam

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset asynchronous active-low
- s_valid_i  in  NUM_CH  per-channel request valid
- s_ready_o  out  NUM_CH  per-channel completion strobe
- s_addr_i  in  NUM_CH*ADDR_W  packed addresses; channel k at [k*ADDR_W +: ADDR_W]
- s_wdata_i  in  NUM_CH*DATA_W  packed write data
- s_we_i  in  NUM_CH*BE_W  packed byte write enables; all-zero means read
- s_rdata_o  out  DATA_W  read data, broadcast to all channels; qualified by s_ready_o
- m_valid_o  out  1  memory request valid
- m_ready_i  in  1  memory completion
- m_addr_o  out  ADDR_W  memory address
- m_wdata_o  out  DATA_W  memory write data
- m_we_o  out  BE_W  memory byte enables
- m_rdata_i  in  DATA_W  memory read data

Behaviour:
- State machine has two states, IDLE and BUSY. Registers: state, grant (index, $clog2(NUM_CH) bits, min 1), rr_ptr (same width).
- Reset (async, rst_n=0): state=IDLE, grant=0, rr_ptr=0.
- Outputs while in reset or IDLE: m_valid_o=0; m_addr_o, m_wdata_o, m_we_o all 0; s_ready_o=0.
- IDLE: if any s_valid_i is set, pick the first asserted channel searching rr_ptr, rr_ptr+1, ... modulo NUM_CH. Register it into grant and go to BUSY. Nothing is driven to memory in this cycle.
- BUSY:
  - m_valid_o=1; m_addr_o, m_wdata_o, m_we_o are muxed combinationally from channel grant.
  - If m_ready_i=1: s_ready_o[grant]=1 combinationally, same cycle; s_rdata_o=m_rdata_i; rr_ptr <= grant+1, wrapping NUM_CH-1 -> 0; state <= IDLE.
  - If m_ready_i=0: hold all outputs and grant unchanged.
- s_rdata_o is always m_rdata_i, unregistered.
- Latency: a request at cycle 0 reaches memory at cycle 1. With zero-wait memory, s_ready_o fires at cycle 1. Each transfer costs at least 2 cycles (one IDLE arbitration cycle between grants).
- Protocol rule: a master holds valid, addr, wdata and we stable until it sees ready. Dropping valid while granted is illegal; the arbiter still completes the memory access. Flag it with an assertion under simulation only.
- Simultaneous requests: served in strict rotation. No channel waits more than NUM_CH grants.
- NUM_CH=1: grant is always 0 and rr_ptr stays 0.
- A new request arriving on the just-served channel in the same cycle as its ready is considered only at the next IDLE, behind the other channels.
- Reset mid-BUSY: the transfer is abandoned immediately, m_valid_o drops asynchronously, and no s_ready_o is issued.

Optional Feature:
- Macro: MEM_ARB_STATS_EN
- With it: extra port stat_cnt_o out NUM_CH*16, holding per-channel 16-bit saturating counters of completed transfers. A counter increments when s_ready_o[k] is high and sticks at 16'hFFFF. Counters are cleared by rst_n.
- Without it: port, counters and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic {IDLE, BUSY} arb_state_e
  - localparam STAT_W=16
  - function clog2_min1 for index widths
- Sub-module mem_arb_rr_pick: purely combinational. Inputs req[NUM_CH] and ptr; outputs any and idx, using the rotated priority search. It is reusable for future multi-bank interconnect.

Test Plan:
- Reset, then ch0 valid at addr 0x100 with 1-cycle ready memory -> m_valid_o at cycle+1 with m_addr_o=0x100; s_ready_o=2'b01 the same cycle; rr_ptr=1.
- Both channels valid continuously (NUM_CH=2) -> grant order 0,1,0,1; each s_ready_o pulse is separated by one IDLE cycle.
- ch1 write of 0xDEADBEEF with we=4'hF while memory stalls 3 cycles -> m_* held stable for 4 cycles; single s_ready_o[1] pulse; read back via ch0 returns 0xDEADBEEF.
- NUM_CH=4 with only ch3 and ch1 requesting and rr_ptr=2 -> ch3 is granted first, then ch1; rr_ptr ends at 2.
- rst_n pulsed low during BUSY with stall -> m_valid_o=0 immediately, no s_ready_o; after release, a pending ch0 request is re-arbitrated from rr_ptr=0.
- MEM_ARB_STATS_EN, 70000 back-to-back ch0 reads -> stat_cnt_o[15:0] saturates at 0xFFFF; ch1 count stays 0.
